// File: rtl/result_mem_reader_if.sv
// Result read-back bus bundle.
// Groups the result-memory read port and the result output stream.
//   mem_rd_en    read strobe to result memory
//   mem_adr      read address
//   mem_rd_data  read data, valid exactly one cycle after mem_rd_en
//   res_data     current unpacked result
//   res_valid    res_data is valid
//   res_ready    consumer accepts (transfer on valid && ready at a clock edge)
//   res_last     final result of the run
// master: the reader side (drives read requests and the result stream).
// slave : the memory/consumer side.
interface result_mem_reader_if #(
  parameter int ADDR_W = 8,
  parameter int RES_W  = 8,
  parameter int PACK   = 4
);
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_adr;
  logic [PACK*RES_W-1:0]   mem_rd_data;
  logic [RES_W-1:0]        res_data;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_last;

  modport master (
    output mem_rd_en,
    output mem_adr,
    input  mem_rd_data,
    output res_data,
    output res_valid,
    input  res_ready,
    output res_last
  );

  modport slave (
    input  mem_rd_en,
    input  mem_adr,
    output mem_rd_data,
    input  res_data,
    input  res_valid,
    output res_ready,
    input  res_last
  );
endinterface

// File: rtl/result_mem_reader.sv
// result_mem_reader
// Reads packed convolution results (PACK results per memory word) back from
// result memory and streams them out one result at a time over valid/ready.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   start     one-cycle launch request, honoured only while idle
//   base_adr  first word address, latched when start is accepted
//   word_cnt  number of words to read, latched when start is accepted
//   bus       result_mem_reader_if.master: memory read port + result stream
//   busy      high whenever a run is in progress (any state but IDLE)
//   done      one-cycle pulse after the final result has transferred
module result_mem_reader #(
  parameter int ADDR_W = 8,
  parameter int RES_W  = 8,
  parameter int PACK   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_adr,
  input  logic [ADDR_W-1:0]          word_cnt,
  result_mem_reader_if.master        bus,
  output logic                       busy,
  output logic                       done
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WORD_W = PACK * RES_W;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   base_q,     base_d;
  logic [ADDR_W-1:0]   cnt_q,      cnt_d;
  logic [ADDR_W-1:0]   issued_q,   issued_d;
  logic [ADDR_W-1:0]   popped_q,   popped_d;
  logic [LANE_W-1:0]   lane_q,     lane_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          occ_q,      occ_d;
  logic                wr_ptr_q,   wr_ptr_d;
  logic                rd_ptr_q,   rd_ptr_d;
  logic [WORD_W-1:0]   fifo_q [2];
  logic [WORD_W-1:0]   fifo_d [2];

  logic [WORD_W-1:0]   head_word;
  logic                res_valid_c;
  logic                res_last_c;
  logic                final_word;
  logic                lane_last;
  logic                xfer;
  logic                push;
  logic                pop;
  logic                rd_en_c;
  int                  lane_off;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    lane_d     = lane_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_d     = fifo_q;
    rd_en_c    = 1'b0;
    bus.mem_adr = '0;

    // Output stage: unpack the head word of the FIFO lane by lane
    head_word   = fifo_q[rd_ptr_q];
    lane_off    = int'(lane_q) * RES_W;
    res_valid_c = (occ_q != 2'd0);
    final_word  = (popped_q == (cnt_q - ADDR_W'(1)));
    lane_last   = (lane_q == LAST_LANE);
    res_last_c  = res_valid_c && final_word && lane_last;
    xfer        = res_valid_c && bus.res_ready;
    pop         = xfer && lane_last;
    // Data from the read issued last cycle lands now; a reset clears the
    // in-flight flag so a read launched before reset is dropped.
    push        = inflight_q;

    bus.res_valid = res_valid_c;
    bus.res_last  = res_last_c;
    bus.res_data  = res_valid_c ? head_word[lane_off +: RES_W] : '0;

    if (xfer) begin
      lane_d = lane_last ? '0 : lane_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      popped_d = popped_q + 1'b1;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_rd_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_adr;
          cnt_d    = word_cnt;
          issued_d = '0;
          popped_d = '0;
          lane_d   = '0;
          state_d  = (word_cnt == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        // Never let buffered plus outstanding words exceed the 2-entry FIFO
        if ((occ_q + {1'b0, inflight_q}) < 2'd2) begin
          rd_en_c     = 1'b1;
          bus.mem_adr = base_q + issued_q;
          issued_d    = issued_q + 1'b1;
          if (issued_q == (cnt_q - ADDR_W'(1))) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (xfer && res_last_c) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d    = rd_en_c;
    bus.mem_rd_en = rd_en_c;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_FIN);
  end

  // Control register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      lane_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      lane_q     <= lane_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Word storage stage; contents are only observed through occupancy
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_result_mem_reader.sv
module tb_result_mem_reader;
  localparam int ADDR_W = 8;
  localparam int RES_W  = 8;
  localparam int PACK   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_adr;
  logic [ADDR_W-1:0] word_cnt;
  logic              busy;
  logic              done;

  result_mem_reader_if #(.ADDR_W(ADDR_W), .RES_W(RES_W), .PACK(PACK)) bus ();

  result_mem_reader #(.ADDR_W(ADDR_W), .RES_W(RES_W), .PACK(PACK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_adr (base_adr),
    .word_cnt (word_cnt),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, junk when not reading
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_adr] : 32'hDEADBEEF;
  end

  // Stream monitor
  logic [7:0] xq[$];
  logic       lq[$];
  logic [7:0] aq[$];
  int         done_cnt  = 0;
  int         rd_cnt    = 0;
  int         valid_cnt = 0;
  int         last_cnt  = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  always @(posedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      xq.push_back(bus.res_data);
      lq.push_back(bus.res_last);
    end
    if (bus.mem_rd_en) begin
      aq.push_back(bus.mem_adr);
      rd_cnt <= rd_cnt + 1;
    end
    if (done)          done_cnt  <= done_cnt + 1;
    if (bus.res_valid) valid_cnt <= valid_cnt + 1;
    if (bus.res_last)  last_cnt  <= last_cnt + 1;
    if (prev_stall && (!bus.res_valid || bus.res_data != prev_data || bus.res_last != prev_last))
      stall_err <= stall_err + 1;
    prev_stall <= bus.res_valid && !bus.res_ready && !rst;
    prev_data  <= bus.res_data;
    prev_last  <= bus.res_last;
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  logic [7:0] expv[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input int idx, input int n);
    check({tag, "_count"}, xq.size() - idx, n);
    for (int i = 0; i < n && (idx + i) < xq.size(); i++) begin
      check($sformatf("%s_res%0d", tag, i), xq[idx+i], expv[i]);
      check($sformatf("%s_last%0d", tag, i), lq[idx+i], (i == n - 1));
    end
  endtask

  // Launch a run and wait (bounded) for done; optionally toggle ready and
  // pulse a second start mid-run.
  task automatic run(input logic [7:0] b, input logic [7:0] c, input bit toggle,
                     input int restart_at, output bit got);
    @(negedge clk);
    base_adr = b; word_cnt = c; start = 1'b1; bus.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (i == restart_at) begin
          start = 1'b1; base_adr = 8'h10; word_cnt = 8'd5;
        end else start = 1'b0;
        if (toggle) bus.res_ready = ~bus.res_ready;
        @(negedge clk);
      end
    end
    start = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int idx, aidx, d0, r0, v0, l0;
    bit got;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5A5A5;
    mem[0]    = 32'h04030201;
    mem[1]    = 32'h08070605;
    mem[8'hFE] = 32'h14131211;
    mem[8'hFF] = 32'h24232221;
    for (int i = 0; i < 43; i++) mem[8'h10 + i] = {4{8'(8'h40 + i)}};

    rst = 1'b1; start = 1'b0; base_adr = '0; word_cnt = '0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_adr",   bus.mem_adr, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_data",  bus.res_data, 0);
    check("rst_last",  bus.res_last, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: cycle-exact two-word run with ready held high
    base_adr = 8'h00; word_cnt = 8'd2; start = 1'b1; bus.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t1_rd_en_c%0d", c), bus.mem_rd_en, (c == 1 || c == 2));
      check($sformatf("t1_adr_c%0d", c),   bus.mem_adr, (c == 2) ? 1 : 0);
      check($sformatf("t1_valid_c%0d", c), bus.res_valid, (c >= 3 && c <= 10));
      check($sformatf("t1_data_c%0d", c),  bus.res_data, (c >= 3 && c <= 10) ? c - 2 : 0);
      check($sformatf("t1_last_c%0d", c),  bus.res_last, (c == 10));
      check($sformatf("t1_done_c%0d", c),  done, (c == 11));
      check($sformatf("t1_busy_c%0d", c),  busy, (c >= 1 && c <= 11));
      @(negedge clk);
    end

    // Test 2: ready toggling each cycle
    expv = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    idx = xq.size(); d0 = done_cnt;
    run(8'h00, 8'd2, 1'b1, -1, got);
    check("t2_done_seen", got, 1);
    check_stream("t2", idx, 8);
    check("t2_stall_stable", stall_err, 0);
    check("t2_done_once", done_cnt - d0, 1);

    // Test 3: zero-word run
    r0 = rd_cnt; v0 = valid_cnt; l0 = last_cnt; d0 = done_cnt;
    @(negedge clk);
    base_adr = 8'h00; word_cnt = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy_c1", busy, 1);
    check("t3_done_c1", done, 1);
    repeat (4) @(negedge clk);
    check("t3_no_reads", rd_cnt - r0, 0);
    check("t3_no_valid", valid_cnt - v0, 0);
    check("t3_no_last",  last_cnt - l0, 0);
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_idle", busy, 0);

    // Test 4: address wrap
    expv = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24,
             8'h01, 8'h02, 8'h03, 8'h04};
    idx = xq.size(); aidx = aq.size();
    run(8'hFE, 8'd3, 1'b0, -1, got);
    check("t4_done_seen", got, 1);
    check("t4_reads", aq.size() - aidx, 3);
    if (aq.size() - aidx >= 3) begin
      check("t4_adr0", aq[aidx],   8'hFE);
      check("t4_adr1", aq[aidx+1], 8'hFF);
      check("t4_adr2", aq[aidx+2], 8'h00);
    end
    check_stream("t4", idx, 12);

    // Test 5: reset after 5 transfers of a 43-word run
    idx = xq.size();
    @(negedge clk);
    base_adr = 8'h10; word_cnt = 8'd43; start = 1'b1; bus.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && (xq.size() - idx) < 5; i++) @(negedge clk);
    check("t5_five_xfers", xq.size() - idx, 5);
    if (xq.size() - idx >= 5) begin
      check("t5_first", xq[idx], 8'h40);
      check("t5_fifth", xq[idx+4], 8'h41);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_rd_en", bus.mem_rd_en, 0);
    check("t5_adr",   bus.mem_adr, 0);
    check("t5_valid", bus.res_valid, 0);
    check("t5_data",  bus.res_data, 0);
    check("t5_last",  bus.res_last, 0);
    check("t5_busy",  busy, 0);
    check("t5_done",  done, 0);
    rst = 1'b0;
    d0 = done_cnt; v0 = valid_cnt;
    repeat (6) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_valid", valid_cnt - v0, 0);
    expv = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    idx = xq.size();
    run(8'h00, 8'd2, 1'b0, -1, got);
    check("t5_rerun_done", got, 1);
    check_stream("t5_rerun", idx, 8);

    // Test 6: start pulsed mid-run is ignored
    idx = xq.size(); d0 = done_cnt; r0 = rd_cnt;
    run(8'h00, 8'd2, 1'b0, 3, got);
    check("t6_done_seen", got, 1);
    repeat (5) @(negedge clk);
    check_stream("t6", idx, 8);
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_reads", rd_cnt - r0, 2);
    check("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
